// File: rtl/gray_pkg.sv
// Shared Gray-code definitions for the encoder/decoder pair.
// Both helpers are WIDTH-generic: operands are zero-extended to 32 bits.
package gray_pkg;

  localparam int unsigned GRAY_W_DEFAULT = 10;
  localparam int unsigned GRAY_W_MAX     = 32;

  // Zero bits above the real word width leave the prefix XOR unchanged.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] gray);
    logic [GRAY_W_MAX-1:0] bin;
    bin[GRAY_W_MAX-1] = gray[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/pipe_reg_elastic.sv
// One valid/ready register slice. It accepts a new word whenever it is empty
// or its current word leaves this cycle, so back-to-back streaming needs no bubble.
module pipe_reg_elastic #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              advance;

  assign advance = !valid_q || out_ready_i;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (advance) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  // NOTE: the data register is reset too, so the visible output word reads 0 after reset.
  // NOTE: state is updated with non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = advance;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/dec_gray2bin.sv
// Two-stage pipelined Gray-to-binary decoder with a step-sequence checker.
// S1 decodes the upper half, S2 finishes the lower half; checker and counter live here.
module dec_gray2bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = GRAY_W_DEFAULT,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     bin,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned LO_W = WIDTH / 2;
  localparam int unsigned HI_W = WIDTH - LO_W;

  logic [HI_W-1:0]  hi_bin;
  logic             s1_valid, s2_ready;
  logic [WIDTH-1:0] s1_data;
  logic [HI_W-1:0]  s1_hi;
  logic [LO_W-1:0]  s1_glo;
  logic [LO_W-1:0]  lo_bin;

  always_comb begin : s1_decode
    logic acc;
    acc    = 1'b0;
    hi_bin = '0;
    for (int i = HI_W - 1; i >= 0; i--) begin
      acc       = acc ^ gray[LO_W + i];
      hi_bin[i] = acc;
    end
  end

  // S1 keeps only the lower Gray bits; the upper ones are already decoded.
  pipe_reg_elastic #(.DATA_W(WIDTH)) u_s1 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({hi_bin, gray[LO_W-1:0]}),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_data)
  );

  assign s1_hi  = s1_data[WIDTH-1:LO_W];
  assign s1_glo = s1_data[LO_W-1:0];

  always_comb begin : s2_decode
    logic acc;
    acc    = s1_hi[0];
    lo_bin = '0;
    for (int i = LO_W - 1; i >= 0; i--) begin
      acc       = acc ^ s1_glo[i];
      lo_bin[i] = acc;
    end
  end

  pipe_reg_elastic #(.DATA_W(WIDTH)) u_s2 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   ({s1_hi, lo_bin}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (bin)
  );

  logic                 hist_vld_q, hist_vld_d;
  logic [WIDTH-1:0]     prev_bin_q, prev_bin_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 out_xfer;

  // Evaluated live against history, so a clr re-qualifies a word already waiting in S2.
  assign step_err = out_valid && hist_vld_q && (bin != prev_bin_q + WIDTH'(1));
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    hist_vld_d = hist_vld_q;
    prev_bin_d = prev_bin_q;
    err_cnt_d  = err_cnt_q;
    if (clr) begin
      hist_vld_d = 1'b0;
      err_cnt_d  = '0;
    end else if (out_xfer) begin
      hist_vld_d = 1'b1;
      prev_bin_d = bin;
      if (step_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_vld_q <= 1'b0;
      prev_bin_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      hist_vld_q <= hist_vld_d;
      prev_bin_q <= prev_bin_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_dec_gray2bin.sv
// Scoreboard bench for dec_gray2bin: expectations are queued on input handshakes
// and popped by an independent monitor on every output transfer.
module tb_dec_gray2bin;
  import gray_pkg::*;

  localparam int W  = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, in_ready, out_valid, out_ready, step_err;
  logic [W-1:0]  gray, bin;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  dec_gray2bin #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gray      (gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [W-1:0] bin;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           or_mode = 0;
  bit           lat_chk = 1'b0;
  logic [W-1:0] cur_bin;
  logic [W-1:0] m_prev;
  bit           m_hist;
  int           m_cnt;
  bit           stalled_prev;
  logic [W-1:0] hold_bin;
  logic         hold_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 9) < 3);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor and reference model.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_cnt        = 0;
      m_hist       = 1'b0;
      stalled_prev = 1'b0;
    end else begin
      exp_t e;
      check("in_ready_occupancy", 32'(in_ready), 32'(!(sb.size() >= 2 && !out_ready)));
      if (stalled_prev) begin
        check("stall_valid", 32'(out_valid), 32'(1));
        check("stall_bin", 32'(bin), 32'(hold_bin));
        check("stall_err", 32'(step_err), 32'(hold_err));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(bin), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("bin", 32'(bin), 32'(e.bin));
          check("step_err", 32'(step_err), 32'(e.err));
          check("err_cnt_running", 32'(err_cnt), 32'(m_cnt));
          if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'(2));
          if (!clr && e.err && m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end
      if (clr) begin
        m_cnt  = 0;
        m_hist = 1'b0;
      end
      stalled_prev = out_valid && !out_ready;
      hold_bin     = bin;
      hold_err     = step_err;
      if (in_valid && in_ready) begin
        e.bin = cur_bin;
        e.err = m_hist && (int'(cur_bin) != (int'(m_prev) + 1) % (1 << W));
        e.cyc = cyc;
        sb.push_back(e);
        m_prev = cur_bin;
        m_hist = 1'b1;
      end
    end
  end

  task automatic send(input logic [W-1:0] g, input logic [W-1:0] b);
    int n = 0;
    gray     = g;
    cur_bin  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendb(input logic [W-1:0] b);
    logic [31:0] g;
    g = bin2gray(32'(b));
    send(g[W-1:0], b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] gv[5];
    logic [W-1:0] bv[5];
    logic [W-1:0] pb;
    gv = '{10'h000, 10'h001, 10'h003, 10'h200, 10'h3FF};
    bv = '{10'h000, 10'h001, 10'h002, 10'h3FF, 10'h2AA};
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; gray = '0; cur_bin = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_bin", 32'(bin), 32'(0));
    check("reset_step_err", 32'(step_err), 32'(0));
    check("reset_err_cnt", 32'(err_cnt), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));

    // Single-word decode vectors, latency checked.
    lat_chk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(gv[i], bv[i]);
      idle(3);
    end
    drain();

    // Full sweep with wrap back to zero.
    pulse_clr();
    for (int i = 0; i <= 1024; i++) sendb(W'(i % 1024));
    drain();
    lat_chk = 1'b0;
    check("sweep_err_cnt", 32'(err_cnt), 32'(0));

    // Random backpressure and random input gaps.
    or_mode = 1;
    pb = '0;
    for (int i = 0; i < 300; i++) begin
      pb = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'(pb + 1);
      if ($urandom_range(0, 2) == 0) idle(1);
      sendb(pb);
    end
    or_mode = 0;
    drain();

    // Step errors, repeats and saturation.
    pulse_clr();
    sendb(5); sendb(6); sendb(8); sendb(9);
    drain();
    check("skip_err_cnt", 32'(err_cnt), 32'(1));
    sendb(9);
    drain();
    check("repeat_err_cnt", 32'(err_cnt), 32'(2));
    for (int i = 0; i < 300; i++) sendb(7);
    drain();
    check("saturated_err_cnt", 32'(err_cnt), 32'(255));

    // Asynchronous reset with both stages full and output stalled.
    or_mode = 2;
    idle(1);
    sendb(8);
    sendb(9);
    check("full_in_ready", 32'(in_ready), 32'(0));
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'(0));
    check("async_bin", 32'(bin), 32'(0));
    check("async_step_err", 32'(step_err), 32'(0));
    check("async_err_cnt", 32'(err_cnt), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    or_mode = 0;
    check("post_reset_in_ready", 32'(in_ready), 32'(1));
    sendb(100);
    sendb(50);
    drain();
    check("post_reset_err_cnt", 32'(err_cnt), 32'(1));

    // Clear between words.
    pulse_clr();
    check("clr_err_cnt", 32'(err_cnt), 32'(0));
    sendb(40);
    sendb(41);
    drain();
    check("after_clr_err_cnt", 32'(err_cnt), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
